// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: opcodes, FSM states and
// the encodings used on the control buses.
package mips_defs;

    localparam int unsigned LARGURA_ESTADO_PADRAO = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        BUSCA     = 4'd0,
        DECOD     = 4'd1,
        END_MEM   = 4'd2,
        LE_MEM    = 4'd3,
        ESCR_LW   = 4'd4,
        ESCR_MEM  = 4'd5,
        EXEC_R    = 4'd6,
        ESCR_R    = 4'd7,
        DESVIO    = 4'd8,
        SALTO     = 4'd9,
        EXEC_ADDI = 4'd10,
        ESCR_ADDI = 4'd11
    } estado_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle control unit and the datapath.
// master = control unit, slave = datapath / observer.
interface unidade_controle_multiciclo_if #(
    parameter int LARGURA_ESTADO = 4
);
    logic [5:0]                opcode;
    logic                      PCWrite;
    logic                      PCWriteCond;
    logic                      IorD;
    logic                      MemRead;
    logic                      MemWrite;
    logic                      MemtoReg;
    logic                      IRWrite;
    logic                      RegWrite;
    logic                      RegDst;
    logic                      ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic [1:0]                ALUOp;
    logic [1:0]                PCSource;
    logic [LARGURA_ESTADO-1:0] estado;

    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        output MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
        output ALUSrcB, ALUOp, PCSource, estado
    );

    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        input  MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
        input  ALUSrcB, ALUOp, PCSource, estado
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Moore FSM sequencing MIPS instructions through fetch, decode,
// execute, memory and write-back for the multicycle datapath.
module unidade_controle_multiciclo
    import mips_defs::*;
#(
    parameter int LARGURA_ESTADO = LARGURA_ESTADO_PADRAO
) (
    input  logic clock,
    input  logic reset,
    unidade_controle_multiciclo_if.master bus
);

    estado_t r_estado;
    estado_t w_prox;
    logic    r_eh_sw;
    logic    r_pos_reset;

    logic       w_pcwrite, w_pcwritecond, w_iord, w_memread;
    logic       w_memwrite, w_memtoreg, w_irwrite, w_regwrite;
    logic       w_regdst, w_alusrca, w_bloqueia;
    logic [1:0] w_alusrcb, w_aluop, w_pcsource;

    // r_pos_reset covers the cycle between release and the first
    // low-sampled edge, so the first real fetch follows that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= BUSCA;
            r_pos_reset <= 1'b1;
        end else begin
            r_estado    <= r_pos_reset ? BUSCA : w_prox;
            r_pos_reset <= 1'b0;
        end
    end

    // lw/sw split is latched at decode; opcode is ignored elsewhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_eh_sw <= 1'b0;
        end else if (r_estado == DECOD) begin
            r_eh_sw <= (bus.opcode == OP_SW);
        end
    end

    always_comb begin
        w_prox = BUSCA;
        case (r_estado)
            BUSCA: w_prox = DECOD;
            DECOD: begin
                case (bus.opcode)
                    OP_R:        w_prox = EXEC_R;
                    OP_LW, OP_SW: w_prox = END_MEM;
                    OP_BEQ:      w_prox = DESVIO;
                    OP_J:        w_prox = SALTO;
                    OP_ADDI:     w_prox = EXEC_ADDI;
                    default:     w_prox = BUSCA;
                endcase
            end
            END_MEM:   w_prox = r_eh_sw ? ESCR_MEM : LE_MEM;
            LE_MEM:    w_prox = ESCR_LW;
            EXEC_R:    w_prox = ESCR_R;
            EXEC_ADDI: w_prox = ESCR_ADDI;
            default:   w_prox = BUSCA;
        endcase
    end

    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_irwrite     = 1'b0;
        w_regwrite    = 1'b0;
        w_regdst      = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = SRCB_REG;
        w_aluop       = ALU_ADD;
        w_pcsource    = PC_ALU;
        case (r_estado)
            BUSCA: begin
                w_memread  = 1'b1;
                w_irwrite  = 1'b1;
                w_alusrcb  = SRCB_4;
                w_pcwrite  = 1'b1;
                w_pcsource = PC_ALU;
            end
            DECOD: w_alusrcb = SRCB_IMM_SH;
            END_MEM, EXEC_ADDI: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_aluop   = ALU_ADD;
            end
            LE_MEM: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            ESCR_MEM: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            ESCR_LW: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            EXEC_R: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_FUNCT;
            end
            ESCR_R: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            ESCR_ADDI: w_regwrite = 1'b1;
            DESVIO: begin
                w_alusrca     = 1'b1;
                w_aluop       = ALU_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = PC_ALUOUT;
            end
            SALTO: begin
                w_pcwrite  = 1'b1;
                w_pcsource = PC_JUMP;
            end
            default: ;
        endcase
    end

    assign w_bloqueia = reset | r_pos_reset;

    assign bus.PCWrite     = w_pcwrite & ~w_bloqueia;
    assign bus.PCWriteCond = w_pcwritecond & ~w_bloqueia;
    assign bus.MemWrite    = w_memwrite & ~w_bloqueia;
    assign bus.IRWrite     = w_irwrite & ~w_bloqueia;
    assign bus.RegWrite    = w_regwrite & ~w_bloqueia;
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_memread;
    assign bus.MemtoReg    = w_memtoreg;
    assign bus.RegDst      = w_regdst;
    assign bus.ALUSrcA     = w_alusrca;
    assign bus.ALUSrcB     = w_alusrcb;
    assign bus.ALUOp       = w_aluop;
    assign bus.PCSource    = w_pcsource;
    assign bus.estado      = LARGURA_ESTADO'(r_estado);

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Randomized bench for the multicycle control unit, checked against
// an instruction-level model of traces and per-state control words.
module tb_unidade_controle_multiciclo;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    unidade_controle_multiciclo_if #(.LARGURA_ESTADO(4)) bus ();

    unidade_controle_multiciclo #(.LARGURA_ESTADO(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } ctl_t;

    // Control word each state must present, straight from the state table.
    function automatic ctl_t esperado(int s);
        ctl_t c;
        c = '0;
        case (s)
            0: begin
                c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.pcw = 1;
            end
            1: c.srcb = 2'b11;
            2, 10: begin
                c.srca = 1; c.srcb = 2'b10;
            end
            3: begin c.mrd = 1; c.iord = 1; end
            4: begin c.rw = 1; c.m2r = 1; end
            5: begin c.mwr = 1; c.iord = 1; end
            6: begin c.srca = 1; c.aluop = 2'b10; end
            7: begin c.rw = 1; c.rdst = 1; end
            8: begin
                c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
            end
            9: begin c.pcw = 1; c.pcsrc = 2'b10; end
            11: c.rw = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t observado();
        ctl_t c;
        c.pcw   = bus.PCWrite;
        c.pcwc  = bus.PCWriteCond;
        c.iord  = bus.IorD;
        c.mrd   = bus.MemRead;
        c.mwr   = bus.MemWrite;
        c.m2r   = bus.MemtoReg;
        c.irw   = bus.IRWrite;
        c.rw    = bus.RegWrite;
        c.rdst  = bus.RegDst;
        c.srca  = bus.ALUSrcA;
        c.srcb  = bus.ALUSrcB;
        c.aluop = bus.ALUOp;
        c.pcsrc = bus.PCSource;
        return c;
    endfunction

    // Expected state trace from BUSCA up to (not including) the return.
    task automatic trace_for(input logic [5:0] op, output int tr[$]);
        tr = {};
        case (op)
            6'b000000: tr = '{0, 1, 6, 7};
            6'b100011: tr = '{0, 1, 2, 3, 4};
            6'b101011: tr = '{0, 1, 2, 5};
            6'b000100: tr = '{0, 1, 8};
            6'b000010: tr = '{0, 1, 9};
            6'b001000: tr = '{0, 1, 10, 11};
            default:   tr = '{0, 1};
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input bit toggle);
        int   tr[$];
        int   n_rw;
        int   n_mw;
        int   exp_rw;
        int   exp_mw;
        ctl_t o;
        ctl_t e;
        n_rw = 0;
        n_mw = 0;
        trace_for(op, tr);
        exp_rw = (op == 6'b000000 || op == 6'b100011 ||
                  op == 6'b001000) ? 1 : 0;
        exp_mw = (op == 6'b101011) ? 1 : 0;
        foreach (tr[i]) begin
            total++;
            if (bus.estado !== tr[i]) begin
                bad++;
                $display("FAIL trace op=%b step=%0d estado=%0d required=%0d",
                         op, i, bus.estado, tr[i]);
            end
            o = observado();
            e = esperado(tr[i]);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL ctrl op=%b state=%0d got=%h required=%h",
                         op, tr[i], o, e);
            end
            n_rw += int'(bus.RegWrite);
            n_mw += int'(bus.MemWrite);
            if (tr[i] == 1 || !toggle) bus.opcode = op;
            else bus.opcode = 6'($urandom);
            @(posedge clock);
            @(negedge clock);
        end
        total++;
        if (bus.estado !== 4'd0) begin
            bad++;
            $display("FAIL return op=%b estado=%0d required=0",
                     op, bus.estado);
        end
        total++;
        if (n_rw !== exp_rw) begin
            bad++;
            $display("FAIL regwrite_pulses op=%b got=%0d required=%0d",
                     op, n_rw, exp_rw);
        end
        total++;
        if (n_mw !== exp_mw) begin
            bad++;
            $display("FAIL memwrite_pulses op=%b got=%0d required=%0d",
                     op, n_mw, exp_mw);
        end
    endtask

    task automatic hold_reset(input int ciclos);
        for (int k = 0; k < ciclos; k++) begin
            @(posedge clock);
            @(negedge clock);
            total++;
            if (bus.estado !== 4'd0 || bus.RegWrite !== 1'b0 ||
                bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
                bad++;
                $display("FAIL in_reset estado=%0d rw=%b irw=%b pcw=%b required=0,0,0,0",
                         bus.estado, bus.RegWrite, bus.IRWrite, bus.PCWrite);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.IRWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL release irw=%b rw=%b required=0,0",
                     bus.IRWrite, bus.RegWrite);
        end
        @(negedge clock);
        total++;
        if (bus.estado !== 4'd0 || bus.IRWrite !== 1'b1 ||
            bus.PCWrite !== 1'b1) begin
            bad++;
            $display("FAIL first_fetch estado=%0d irw=%b pcw=%b required=0,1,1",
                     bus.estado, bus.IRWrite, bus.PCWrite);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'b111111;
        @(negedge clock);
        hold_reset(2);
    endtask

    task automatic test_r();
        run_instr(6'b000000, 1'b0);
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 1'b0);
    endtask

    task automatic test_sw_beq_j();
        run_instr(6'b101011, 1'b0);
        run_instr(6'b000100, 1'b0);
        run_instr(6'b000010, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 1'b0);
        run_instr(6'b000000, 1'b1);
        run_instr(6'b100011, 1'b1);
        run_instr(6'b101011, 1'b1);
    endtask

    task automatic test_addi();
        run_instr(6'b001000, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.opcode = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        total++;
        if (bus.estado !== 4'd7) begin
            bad++;
            $display("FAIL reach_escr_r estado=%0d required=7", bus.estado);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL abort_write rw=%b required=0", bus.RegWrite);
        end
        @(negedge clock);
        hold_reset(2);
    endtask

    task automatic test_back_to_back();
        logic [5:0] legais [6];
        logic [5:0] op;
        legais = '{6'b000000, 6'b100011, 6'b101011,
                   6'b000100, 6'b000010, 6'b001000};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else op = legais[$urandom_range(0, 5)];
            run_instr(op, bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.opcode = 6'b000000;
        test_reset();
        test_r();
        test_lw();
        test_sw_beq_j();
        test_illegal();
        test_addi();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
